peak_tone_synth: RTL

- Write-side counterpart of the codec capture path: turns the 12 pitch-class peak flags from the note finder into a sawtooth chord and streams it into the audio codec's DAC write interface.
- One sample is produced per accepted codec write, so the output rate follows the codec FIFO.
- Sits between the note finder's peaks output and the codec write, writedata_left and writedata_right signals in the top level.

---
 rtl/peak_tone_synth.sv | 126 ++++++++++++
 1 files changed

// File: rtl/peak_tone_synth.sv
// Sawtooth chord synthesiser: mixes one saw oscillator per latched pitch-class peak
// and hands each sample to the codec DAC write port, one sample per accepted write.
module peak_tone_synth #(
  parameter int PW         = 24,
  parameter int BASE_INC   = 91435,
  parameter int GAIN_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               peaksIn [0:11],
  input  logic               peaksValid,
  input  logic               writeReady,
  output logic               doingWrite,
  output logic signed [23:0] writeDataLeft,
  output logic signed [23:0] writeDataRight
);

  localparam int SW = 24 + GAIN_SHIFT;

  function automatic logic [PW-1:0] calcInc(input int k);
    logic [31:0] r;
    logic [63:0] prod;
    case (k)
      0:       r = 32'd32768;
      1:       r = 32'd34716;
      2:       r = 32'd36781;
      3:       r = 32'd38968;
      4:       r = 32'd41285;
      5:       r = 32'd43740;
      6:       r = 32'd46341;
      7:       r = 32'd49097;
      8:       r = 32'd52016;
      9:       r = 32'd55109;
      10:      r = 32'd58386;
      11:      r = 32'd61858;
      default: r = 32'd32768;
    endcase
    prod = 64'(BASE_INC) * 64'(r);
    return PW'(prod >> 15);
  endfunction

  localparam logic [PW-1:0] INC [12] = '{
    calcInc(0), calcInc(1), calcInc(2),  calcInc(3),
    calcInc(4), calcInc(5), calcInc(6),  calcInc(7),
    calcInc(8), calcInc(9), calcInc(10), calcInc(11)
  };

  typedef enum logic [1:0] {COMPUTE, SCALE, WRITE} state_t;

  state_t             state_q;
  logic [3:0]         idx_q;
  logic [PW-1:0]      phase_q [12];
  logic [11:0]        peaks_q;
  logic [11:0]        snap_q;
  logic signed [19:0] sum_q;
  logic               doingWrite_q;
  logic signed [23:0] data_q;

  logic [11:0]        peaksPacked;
  logic [15:0]        phaseTop;
  logic signed [15:0] saw;
  logic               enSel;
  logic signed [19:0] sumD;
  logic signed [SW-1:0] scaled;
  logic [SW-24:0]     upper;
  logic signed [23:0] dataD;

  // At idx 0 the snapshot is being taken this very edge, so read the live latch.
  always_comb begin
    for (int k = 0; k < 12; k++) peaksPacked[k] = peaksIn[k];
    phaseTop = phase_q[idx_q][PW-1 -: 16];
    saw      = signed'({~phaseTop[15], phaseTop[14:0]});
    enSel    = (idx_q == 4'd0) ? peaks_q[0] : snap_q[idx_q];
    sumD     = ((idx_q == 4'd0) ? 20'sd0 : sum_q) + (enSel ? 20'(saw) : 20'sd0);
    scaled   = SW'(sum_q) <<< GAIN_SHIFT;
    upper    = scaled[SW-1:23];
    if ((&upper) || !(|upper)) dataD = scaled[23:0];
    else                       dataD = upper[SW-24] ? 24'h800000 : 24'h7FFFFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= COMPUTE;
      idx_q        <= 4'd0;
      for (int k = 0; k < 12; k++) phase_q[k] <= '0;
      peaks_q      <= '0;
      snap_q       <= '0;
      sum_q        <= '0;
      doingWrite_q <= 1'b0;
      data_q       <= '0;
    end else begin
      if (peaksValid) peaks_q <= peaksPacked;
      case (state_q)
        COMPUTE: begin
          phase_q[idx_q] <= phase_q[idx_q] + INC[idx_q];
          sum_q          <= sumD;
          if (idx_q == 4'd0) snap_q <= peaks_q;
          if (idx_q == 4'd11) begin
            idx_q   <= 4'd0;
            state_q <= SCALE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        SCALE: begin
          data_q       <= dataD;
          doingWrite_q <= 1'b1;
          state_q      <= WRITE;
        end
        WRITE: begin
          if (writeReady) begin
            doingWrite_q <= 1'b0;
            idx_q        <= 4'd0;
            state_q      <= COMPUTE;
          end
        end
        default: state_q <= COMPUTE;
      endcase
    end
  end

  assign doingWrite     = doingWrite_q;
  assign writeDataLeft  = data_q;
  assign writeDataRight = data_q;

endmodule
